dp32_acc: RTL and testbench
===========================

# dp32_acc

Sequential accumulator that consumes the dp32 SIMD dot-product result bundle one beat at a time. It selects one precision lane per vector, zero-extends it, and sums it over a multi-beat vector. It returns the total through a valid/ready output handshake. It sits directly downstream of the combinational dp32 unit and turns its single-word outputs into arbitrary-length dot products.

## Interface
- ACC_W, 72, accumulator and result width in bits; must be at least 64.
- CNT_W, 9, beat-counter width in bits.
- CLK  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous, active-low reset.
- in_valid  input  1  a result beat is presented.
- in_ready  output  1  the block can accept a beat.
- in_last  input  1  the current beat is the final beat of its vector.
- mode  input  3  lane select; sampled only on the first beat of a vector.
  - 0: mul_int32
  - 1: sum_int16
  - 2: sum_int8
  - 3: sum_int4
  - 4: sum_int2
  - 5 to 7: illegal.
- mul_int32  input  64  dp32 32-bit product.
- sum_int16  input  33  dp32 16-bit lane sum.
- sum_int8  input  18  dp32 8-bit lane sum.
- sum_int4  input  11  dp32 4-bit lane sum.
- sum_int2  input  8  dp32 2-bit lane sum.
- out_valid  output  1  a result is held.
- out_ready  input  1  the consumer takes the result.
- out_sum  output  ACC_W  accumulated total.
- out_count  output  CNT_W  number of beats in the vector; saturates at all-ones.
- out_ovf  output  1  the accumulator carried out of ACC_W during the vector.
- out_err  output  1  the vector used an illegal mode.

## Operation
- All dp32 inputs are unsigned. The selected lane is zero-extended to ACC_W before it is added.
- States:
  - IDLE: waiting for the first beat.
  - ACC: accumulating mid-vector.
  - HOLD: result presented.
- Transitions:
  - IDLE → ACC on accept with in_last=0.
  - IDLE → HOLD on accept with in_last=1.
  - ACC → HOLD on accept with in_last=1.
  - HOLD → IDLE on out_valid & out_ready.
- Accept means in_valid & in_ready. in_ready = 1 in IDLE and ACC, and 0 in HOLD.
- First-beat accept (in IDLE):
  - latch mode into mode_r;
  - acc = lane;
  - count = 1;
  - ovf = 0;
  - err = (mode > 4).
- Later accepts (in ACC):
  - acc = acc + lane(mode_r), modulo 2^ACC_W;
  - ovf is set sticky if the add carries out;
  - count increments and saturates at 2^CNT_W − 1.
- A changing mode input mid-vector is ignored.
- Illegal mode: the lane value is 0 for every beat of the vector and out_err = 1. Accumulation still runs and the vector still completes.
- HOLD: out_sum, out_count, out_ovf and out_err are stable while out_valid=1 and out_ready=0.
- On handshake the block returns to IDLE. acc, count, ovf and err clear in that same edge.
- An in_valid that stays asserted with in_ready=0 is not consumed; the producer must hold its data.
- No back-to-back overlap: a new vector's first beat is accepted only in IDLE, i.e. at earliest the cycle after the output handshake.

## Timing
- Reset values (asynchronous, immediate on nrst=0):
  - state = IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - out_sum = 0;
  - out_count = 0;
  - out_ovf = 0;
  - out_err = 0.
- Throughput: one beat per cycle while in IDLE or ACC.
- Latency: out_valid rises on the edge that accepts the in_last beat and is visible the next cycle. out_sum includes that beat's lane.
- The minimum vector is 1 beat, which gives 1 cycle to out_valid.
- out_valid drops in the cycle after the handshake. in_ready rises in that same cycle.
- Reset mid-vector or in HOLD discards all partial state. The first beat after reset release starts a new vector.
- Registered outputs only. in_ready is decoded from the state register; there is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset, then mode=0, one beat with in_last=1 and mul_int32=0xFFFFFFFE00000001 -> next cycle: out_valid=1, out_sum=0xFFFFFFFE00000001, out_count=1, out_ovf=0, out_err=0.
- mode=2, four beats of sum_int8=0x3F804, last on beat 4; mode changes to 0 on beat 2 -> out_sum=0xFE010, out_count=4. The mid-vector mode change is ignored.
- mode=4, sum_int2 = 144, 8, 144; out_ready held low for 5 cycles -> out_sum=296, out_count=3. The output stays stable and in_ready=0 throughout HOLD. The handshake returns the block to IDLE with acc cleared.
- mode=0, 257 beats of 0xFFFFFFFE00000001 -> out_ovf=1 and out_sum = 257×value mod 2^72. Checks the carry-out flag and ACC_W-bit wraparound of the sum.
- mode=6, two beats -> out_err=1, out_sum=0, out_count=2.
- Assert nrst=0 mid-vector after 3 beats of mode=1 with sum_int16=0x1FFFC0002 -> out_valid=0 immediately. The next 1-beat vector with sum_int16=0x1FFFC0002 gives out_sum=0x1FFFC0002 and out_count=1.

Source files
------------

// File: rtl/dp32_acc_if.sv
// dp32_acc bundle: dp32 result beats in, accumulated total out.
// Both sides use a valid/ready handshake.
interface dp32_acc_if #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [2:0]       mode;
  logic [63:0]      mul_int32;
  logic [32:0]      sum_int16;
  logic [17:0]      sum_int8;
  logic [10:0]      sum_int4;
  logic [7:0]       sum_int2;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_err;

  modport master (
    output in_valid, in_last, mode,
    output mul_int32, sum_int16, sum_int8,
    output sum_int4, sum_int2, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_count, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_last, mode,
    input  mul_int32, sum_int16, sum_int8,
    input  sum_int4, sum_int2, out_ready,
    output in_ready, out_valid, out_sum,
    output out_count, out_ovf, out_err
  );
endinterface

// File: rtl/dp32_acc.sv
// dp32_acc: sums one zero-extended dp32 lane over a
// multi-beat vector and presents the total on a handshake.
module dp32_acc #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 9
) (
  input  logic     CLK,
  input  logic     nrst,
  dp32_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state;
  logic [2:0]       mode_r;
  logic [2:0]       sel;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] lane;
  logic [ACC_W:0]   add;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             err_r;
  logic             vld_r;

  // Mode is only honoured on the first beat.
  assign sel = (state == IDLE) ? bus.mode : mode_r;

  // Lane select; illegal modes contribute zero.
  always_comb begin
    lane = '0;
    unique case (1'b1)
      sel == 3'd0: lane = ACC_W'(bus.mul_int32);
      sel == 3'd1: lane = ACC_W'(bus.sum_int16);
      sel == 3'd2: lane = ACC_W'(bus.sum_int8);
      sel == 3'd3: lane = ACC_W'(bus.sum_int4);
      sel == 3'd4: lane = ACC_W'(bus.sum_int2);
      default:     lane = '0;
    endcase
  end

  // Extra top bit captures the carry out of ACC_W.
  always_comb begin
    add = {1'b0, acc_r} + {1'b0, lane};
  end

  // Vector FSM with accumulator and result registers.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      mode_r <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
      vld_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mode_r <= bus.mode;
            acc_r  <= lane;
            cnt_r  <= CNT_W'(1);
            ovf_r  <= 1'b0;
            err_r  <= (bus.mode > 3'd4);
            if (bus.in_last) begin
              state <= HOLD;
              vld_r <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc_r <= add[ACC_W-1:0];
            ovf_r <= ovf_r | add[ACC_W];
            if (cnt_r != '1) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
            if (bus.in_last) begin
              state <= HOLD;
              vld_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= IDLE;
            vld_r <= 1'b0;
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = vld_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_count = cnt_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.out_err   = err_r;

endmodule

// File: tb/tb_dp32_acc.sv
// Directed bench for dp32_acc: hand-computed sums,
// counts, flags and handshake behaviour.
module tb_dp32_acc;

  logic CLK;
  logic nrst;
  int   n_tests;
  int   n_fail;

  logic [79:0] big;
  logic [63:0] v64;

  dp32_acc_if #(.ACC_W(72), .CNT_W(9)) bus ();

  dp32_acc #(.ACC_W(72), .CNT_W(9)) u_dut (
    .CLK  (CLK),
    .nrst (nrst),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic        last,
                      input logic [2:0]  m,
                      input logic [63:0] m32,
                      input logic [32:0] s16,
                      input logic [17:0] s8,
                      input logic [10:0] s4,
                      input logic [7:0]  s2);
    bus.in_valid  = 1'b1;
    bus.in_last   = last;
    bus.mode      = m;
    bus.mul_int32 = m32;
    bus.sum_int16 = s16;
    bus.sum_int8  = s8;
    bus.sum_int4  = s4;
    bus.sum_int2  = s2;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.mode      = 3'd0;
    bus.mul_int32 = '0;
    bus.sum_int16 = '0;
    bus.sum_int8  = '0;
    bus.sum_int4  = '0;
    bus.sum_int2  = '0;
    bus.out_ready = 1'b0;
    #12 nrst = 1'b1;
    @(posedge CLK);
    #1;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    chk("rst_err", bus.out_err, 0);

    // 1-beat mul_int32 vector
    v64 = 64'hFFFF_FFFE_0000_0001;
    send(1, 3'd0, v64, 33'h1_2345_6789, 18'h1, 11'h1, 8'h1);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_sum", bus.out_sum, 80'hFFFF_FFFE_0000_0001);
    chk("t1_count", bus.out_count, 1);
    chk("t1_ovf", bus.out_ovf, 0);
    chk("t1_err", bus.out_err, 0);
    chk("t1_in_ready", bus.in_ready, 0);
    take();
    chk("t1_drop", bus.out_valid, 0);
    chk("t1_ready_back", bus.in_ready, 1);
    chk("t1_clr", bus.out_sum, 0);

    // sum_int8, mode change on beat 2 ignored
    send(0, 3'd2, 64'h7, '0, 18'h3F804, '0, '0);
    send(0, 3'd0, 64'h1234, '0, 18'h3F804, '0, '0);
    send(0, 3'd0, 64'h1234, '0, 18'h3F804, '0, '0);
    chk("t2_mid_valid", bus.out_valid, 0);
    send(1, 3'd0, 64'h1234, '0, 18'h3F804, '0, '0);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_sum", bus.out_sum, 80'hFE010);
    chk("t2_count", bus.out_count, 4);
    take();

    // sum_int2 with a stalled consumer
    send(0, 3'd4, '0, '0, '0, '0, 8'd144);
    send(0, 3'd4, '0, '0, '0, '0, 8'd8);
    send(1, 3'd4, '0, '0, '0, '0, 8'd144);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", bus.out_valid, 1);
      chk("t3_hold_sum", bus.out_sum, 296);
      chk("t3_hold_count", bus.out_count, 3);
      chk("t3_hold_ready", bus.in_ready, 0);
      @(posedge CLK);
      #1;
    end
    take();
    chk("t3_drop", bus.out_valid, 0);
    chk("t3_clr_sum", bus.out_sum, 0);
    chk("t3_clr_cnt", bus.out_count, 0);

    // 257 beats of a near-2^64 product: wraps 72 bits
    for (int i = 0; i < 257; i++) begin
      send(i == 256, 3'd0, v64, '0, '0, '0, '0);
    end
    big = 80'h0_FFFF_FFFE_0000_0001 * 80'd257;
    chk("t4_valid", bus.out_valid, 1);
    chk("t4_ovf", bus.out_ovf, 1);
    chk("t4_sum", bus.out_sum, {8'h0, big[71:0]});
    chk("t4_count", bus.out_count, 257);
    take();
    chk("t4_ovf_clr", bus.out_ovf, 0);

    // illegal mode
    send(0, 3'd6, v64, 33'h5, 18'h5, 11'h5, 8'h5);
    send(1, 3'd1, v64, 33'h5, 18'h5, 11'h5, 8'h5);
    chk("t5_valid", bus.out_valid, 1);
    chk("t5_err", bus.out_err, 1);
    chk("t5_sum", bus.out_sum, 0);
    chk("t5_count", bus.out_count, 2);
    take();
    chk("t5_err_clr", bus.out_err, 0);

    // count saturation: 513 beats of 1
    for (int i = 0; i < 513; i++) begin
      send(i == 512, 3'd4, '0, '0, '0, '0, 8'd1);
    end
    chk("t6_count_sat", bus.out_count, 511);
    chk("t6_sum", bus.out_sum, 513);
    chk("t6_ovf", bus.out_ovf, 0);
    take();

    // reset mid-vector
    send(0, 3'd1, '0, 33'h1_FFFC_0002, '0, '0, '0);
    send(0, 3'd1, '0, 33'h1_FFFC_0002, '0, '0, '0);
    send(0, 3'd1, '0, 33'h1_FFFC_0002, '0, '0, '0);
    chk("t7_partial", bus.out_sum, 80'h5_FFF4_0006);
    #2 nrst = 1'b0;
    #1;
    chk("t7_rst_valid", bus.out_valid, 0);
    chk("t7_rst_sum", bus.out_sum, 0);
    chk("t7_rst_count", bus.out_count, 0);
    chk("t7_rst_ready", bus.in_ready, 1);
    #3 nrst = 1'b1;
    @(posedge CLK);
    #1;
    send(1, 3'd1, '0, 33'h1_FFFC_0002, '0, '0, '0);
    chk("t7_valid", bus.out_valid, 1);
    chk("t7_sum", bus.out_sum, 80'h1_FFFC_0002);
    chk("t7_count", bus.out_count, 1);
    take();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
